input_conditioner: RTL
======================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
- REQ-001: Parameter CHANNELS, default 3: number of independent input channels (1..32).
- REQ-002: Parameter CNT_W, default 32: width of the debounce and repeat counters and their timing inputs.
- REQ-003: clk  input  1  single system clock; all state on rising edge.
- REQ-004: arst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: width  input  CNT_W  debounce stability window in clk cycles, shared by all channels.
- REQ-006: d  input  CHANNELS  raw asynchronous inputs (switches/buttons).
- REQ-007: q  output  CHANNELS  debounced levels, registered.
- REQ-008: rise  output  CHANNELS  one-cycle pulse when q[i] goes 0->1, registered.
- REQ-009: fall  output  CHANNELS  one-cycle pulse when q[i] goes 1->0, registered.
- REQ-010: any_evt  output  1  OR of all rise and fall bits.
- REQ-011: rpt_delay  input  CNT_W  cycles from rise to first repeat pulse.
- REQ-012: rpt_period  input  CNT_W  cycles between subsequent repeat pulses.
- REQ-013: rpt  output  CHANNELS  one-cycle auto-repeat pulses, registered.

Function
- REQ-014: Each d[i] passes through a 2-flop synchronizer; its second-stage output s[i] is the only value the debounce logic reads.
- REQ-015: Effective window w_eff = 1 when width == 0, else width.
- REQ-016: Per channel, at each edge: if s == q, cnt <= 0; else if cnt >= w_eff-1, q <= s and cnt <= 0; else cnt <= cnt+1.
- REQ-017: d[i] changing before edge 0 and held stable updates q[i] at edge w_eff+1.
- REQ-018: Any cycle with s == q during a count discards the count; glitches shorter than w_eff sampled cycles never reach q.
- REQ-019: rise[i]/fall[i] assert in the same cycle q[i] changes, for exactly one cycle; otherwise 0.
- REQ-020: Changing width takes effect next edge; a channel whose cnt already >= new w_eff-1 and still mismatched flips at that edge.
- REQ-021: Channels are fully independent; simultaneous transitions on several channels each produce their own pulses in the same cycle.
- REQ-022: Counters saturate logically via REQ-016 and never wrap.
- REQ-023: Repeat state per channel: IDLE (q=0), DELAY, REPEAT.
- REQ-024: Transitions: IDLE->DELAY on rise, rcnt <= 0; DELAY->REPEAT when rcnt reaches max(rpt_delay,1)-1, pulse rpt, rcnt <= 0; REPEAT pulses rpt and clears rcnt each time rcnt reaches max(rpt_period,1)-1; any state->IDLE on fall, no rpt in that cycle.

Reset
- REQ-025: While arst_n = 0, all synchronizer flops, q, rise, fall, rpt, cnt and rcnt are 0 and repeat state is IDLE, regardless of clk.
- REQ-026: Reset asserted mid-count aborts the count; after release, a d[i] held at 1 requires a full new window (q at edge w_eff+1 after release).
- REQ-027: Reset release is taken synchronously at the first clk edge after arst_n rises; no pulse is generated by release itself.

Configuration
- REQ-028: Macro INPUT_CONDITIONER_AUTOREPEAT_EN defined: REQ-023/024 repeat logic is built.
- REQ-029: Macro undefined: no repeat logic, rpt_delay/rpt_period ignored, rpt tied to 0; debounce behaviour identical.

Verification
- REQ-030: width=4, d[0] 0->1 before edge 0, held -> q[0]=1 and rise[0]=1 at edge 5; rise[0]=0 at edge 6.
- REQ-031: width=4, d[1] high for 3 cycles then low -> q[1], rise[1] never assert.
- REQ-032: width=0, d[2] 0->1 -> q[2] at edge 2; then d[2] 1->0 -> fall[2] single pulse two edges later.
- REQ-033: width=8, d=3'b111 held, arst_n pulsed low at edge 5 -> all outputs 0 during reset; q=3'b111 at edge 9 after release.
- REQ-034: Macro on, width=2, rpt_delay=10, rpt_period=4, d[0] held high -> rpt[0] 10 cycles after rise[0], then every 4 cycles; stops on fall[0].
- REQ-035: Macro off, same stimulus as REQ-034 -> rpt stays 3'b000 throughout; q/rise/fall match macro-on run.

Source files
------------

// File: rtl/input_conditioner.sv
// Per-channel 2-flop synchronizer, stability-window debouncer and edge pulses, with optional
// auto-repeat pulses built when INPUT_CONDITIONER_AUTOREPEAT_EN is defined.
module input_conditioner #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [CNT_W-1:0]    width,
  input  logic [CHANNELS-1:0] d,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_evt,
  input  logic [CNT_W-1:0]    rpt_delay,
  input  logic [CNT_W-1:0]    rpt_period,
  output logic [CHANNELS-1:0] rpt
);

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] q_q, q_d, rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CNT_W-1:0]    w_lim;

  // A zero window behaves as a one-cycle window.
  assign w_lim = (width == '0) ? '0 : width - CNT_W'(1);

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == q_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= w_lim) begin
        q_d[i]   = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      q_q     <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < int'(CHANNELS); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign q       = q_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign any_evt = |{rise_q, fall_q};

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

  rpt_state_e          state_q [CHANNELS];
  rpt_state_e          state_d [CHANNELS];
  logic [CNT_W-1:0]    rcnt_q  [CHANNELS];
  logic [CNT_W-1:0]    rcnt_d  [CHANNELS];
  logic [CHANNELS-1:0] rpt_q, rpt_d;
  logic [CNT_W-1:0]    dly_lim, per_lim;

  assign dly_lim = (rpt_delay == '0) ? '0 : rpt_delay - CNT_W'(1);
  assign per_lim = (rpt_period == '0) ? '0 : rpt_period - CNT_W'(1);

  always_comb begin
    rpt_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (rise_d[i]) begin
            state_d[i] = StDelay;
            rcnt_d[i]  = '0;
          end
        end
        StDelay, StRepeat: begin
          // A fall wins over a due repeat pulse in the same cycle.
          if (fall_d[i]) begin
            state_d[i] = StIdle;
            rcnt_d[i]  = '0;
          end else if (rcnt_q[i] >= ((state_q[i] == StDelay) ? dly_lim : per_lim)) begin
            state_d[i] = StRepeat;
            rcnt_d[i]  = '0;
            rpt_d[i]   = 1'b1;
          end else begin
            rcnt_d[i] = rcnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = StIdle;
          rcnt_d[i]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rpt_q <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        state_q[i] <= StIdle;
        rcnt_q[i]  <= '0;
      end
    end else begin
      rpt_q <= rpt_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  assign rpt = rpt_q;
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{rpt_delay, rpt_period};
  assign rpt = '0;
`endif

endmodule
